// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared FSM state type and grant-index width helper for the UART TX arbiter.
package uart_arb_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_SETTLE = 1'b1} state_t;
  function automatic int grant_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational rotate-priority picker, first set request at or after i_ptr (wrapping).
module uart_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int GW = grant_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [GW-1:0] i_ptr,
  output logic [GW-1:0] o_idx,
  output logic          o_any
);
  logic [N-1:0] w_rot;
  logic [GW:0]  w_sum;
  assign w_rot = N'({i_req, i_req} >> i_ptr);
  assign o_any = |i_req;
  // Descending scan so the smallest offset from i_ptr wins.
  always_comb begin
    w_sum = '0;
    for (int k = N - 1; k >= 0; k--)
      if (w_rot[k]) w_sum = (GW+1)'(i_ptr) + (GW+1)'(k);
    o_idx = GW'(w_sum >= (GW+1)'(N) ? w_sum - (GW+1)'(N) : w_sum);
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of the uart_fifo transmit port among NUM_REQ byte sources.
// Define UART_TX_ARB_LOCK_EN to keep multi-byte packets (req_last framing) contiguous.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int CNT_W   = 16,
  localparam int GRANT_W = grant_w(NUM_REQ)
) (
  input  logic                 Pclk,
  input  logic                 RESET_N,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic [7:0]           tx_byte,
  output logic                 transmit,
  input  logic                 tx_fifo_full,
  output logic [GRANT_W-1:0]   grant_id,
  output logic                 busy,
  output logic [CNT_W-1:0]     tx_count
);
  state_t             r_state;
  logic [GRANT_W-1:0] r_ptr;
  logic [GRANT_W-1:0] w_g;
  logic [GRANT_W-1:0] w_next;
  logic [NUM_REQ-1:0] w_req;
  logic [7:0]         w_byte;
  logic               w_any;
  logic               w_go;
`ifdef UART_TX_ARB_LOCK_EN
  logic               r_lock;
  logic [GRANT_W-1:0] r_owner;
  assign w_req = r_lock ? req_valid & (NUM_REQ'(1) << r_owner) : req_valid;
`else
  logic w_unused_last;
  assign w_unused_last = ^req_last;
  assign w_req = req_valid;
`endif
  uart_rr_pick #(.N(NUM_REQ), .GW(GRANT_W)) u_pick (
    .i_req(w_req),
    .i_ptr(r_ptr),
    .o_idx(w_g),
    .o_any(w_any)
  );
  assign w_go   = r_state == ST_IDLE && w_any && !tx_fifo_full;
  assign w_next = w_g == GRANT_W'(NUM_REQ - 1) ? '0 : w_g + 1'b1;
  always_comb begin
    w_byte = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (w_g == GRANT_W'(i)) w_byte = req_data[8*i +: 8];
  end
  // SETTLE always follows a grant so uart_fifo can update tx_fifo_full before the next pick.
  always_ff @(posedge Pclk or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state  <= ST_IDLE;
      r_ptr    <= '0;
      req_ack  <= '0;
      tx_byte  <= '0;
      transmit <= 1'b0;
      grant_id <= '0;
      busy     <= 1'b0;
      tx_count <= '0;
`ifdef UART_TX_ARB_LOCK_EN
      r_lock   <= 1'b0;
      r_owner  <= '0;
`endif
    end else begin
      r_state  <= w_go ? ST_SETTLE : ST_IDLE;
      transmit <= w_go;
      busy     <= w_go;
      req_ack  <= w_go ? NUM_REQ'(1) << w_g : '0;
      if (w_go) begin
        tx_byte  <= w_byte;
        grant_id <= w_g;
        tx_count <= tx_count + 1'b1;
`ifdef UART_TX_ARB_LOCK_EN
        if (req_last[w_g]) begin
          r_lock <= 1'b0;
          r_ptr  <= w_next;
        end else begin
          r_lock  <= 1'b1;
          r_owner <= w_g;
        end
`else
        r_ptr <= w_next;
`endif
      end
    end
  end
endmodule
